panel_sequencer: RTL

PANEL_SEQUENCER -- requirements
Module: panel_sequencer

---
 rtl/panel_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/panel_sequencer.sv
// Front-panel button sequencer: debounces a push button, classifies short and long presses, and
// issues STOP/CONTINUE or SWMCL+LOAD pulse sequences to the CPU board, then watches for the RUN_n acknowledge.
module panel_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 393216,
  parameter int unsigned PULSE_CYCLES    = 3932,
  parameter int unsigned LONG_CYCLES     = 78643200,
  parameter int unsigned ACK_CYCLES      = 3932160
) (
  input  logic       sysclk,
  input  logic       sys_rst_n,
  input  logic       btn_n,
  input  logic       RUN_n,
  output logic       STOP_n,
  output logic       CONTINUE_n,
  output logic       SWMCL_n,
  output logic       LOAD_n,
  output logic       busy,
  output logic       ack_err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    PULSE    = 3'd2,
    GAP      = 3'd3,
    WAIT_ACK = 3'd4,
    WAIT_REL = 3'd5
  } state_e;

  // The selector value doubles as the bit index into the active-low pulse vector.
  typedef enum logic [1:0] {
    SEL_STOP  = 2'd0,
    SEL_CONT  = 2'd1,
    SEL_SWMCL = 2'd2,
    SEL_LOAD  = 2'd3
  } sel_e;

  localparam int unsigned MAX_PL = (PULSE_CYCLES > LONG_CYCLES) ? PULSE_CYCLES : LONG_CYCLES;
  localparam int unsigned MAX_T  = (MAX_PL > ACK_CYCLES) ? MAX_PL : ACK_CYCLES;
  localparam int unsigned TW     = $clog2(MAX_T + 1);
  localparam int unsigned DW     = $clog2(DEBOUNCE_CYCLES + 1);

  logic          btn_s1_q, btn_s2_q, run_s1_q, run_s2_q;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  state_e        state_q, state_d;
  sel_e          sel_q, sel_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          ack_err_q, ack_err_d;
  logic          busy_q;
  logic [3:0]    pulse_n_q, pulse_n_d;

  // NOTE: sequential state is only ever updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, regardless of process evaluation order.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      btn_s1_q <= 1'b1;
      btn_s2_q <= 1'b1;
      run_s1_q <= 1'b1;
      run_s2_q <= 1'b1;
    end else begin
      btn_s1_q <= btn_n;
      btn_s2_q <= btn_s1_q;
      run_s1_q <= RUN_n;
      run_s2_q <= run_s1_q;
    end
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (btn_s2_q != db_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) db_d = btn_s2_q;
      else                                      db_cnt_d = db_cnt_q + DW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    ack_err_d = ack_err_q;
    // The shared timer only advances below its terminal value, so it saturates and never wraps.
    case (state_q)
      IDLE: begin
        if (!db_q) begin
          state_d   = HOLD;
          cnt_d     = '0;
          ack_err_d = 1'b0;
        end
      end
      HOLD: begin
        if (db_q) begin
          sel_d   = run_s2_q ? SEL_CONT : SEL_STOP;
          state_d = PULSE;
          cnt_d   = '0;
        end else if (cnt_q == TW'(LONG_CYCLES - 1)) begin
          sel_d   = SEL_SWMCL;
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      PULSE: begin
        if (cnt_q == TW'(PULSE_CYCLES - 1)) begin
          cnt_d = '0;
          case (sel_q)
            SEL_STOP, SEL_CONT: state_d = WAIT_ACK;
            SEL_SWMCL:          state_d = GAP;
            default:            state_d = WAIT_REL;
          endcase
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      GAP: begin
        if (cnt_q == TW'(PULSE_CYCLES - 1)) begin
          sel_d   = SEL_LOAD;
          state_d = PULSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WAIT_ACK: begin
        // STOP is acknowledged by the CPU dropping into OPCOM (RUN_n high), CONTINUE by running.
        if (run_s2_q == (sel_q == SEL_STOP)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TW'(ACK_CYCLES - 1)) begin
          ack_err_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      WAIT_REL: begin
        if (db_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from next state and registered, so no input reaches a pin combinationally.
  always_comb begin
    pulse_n_d = 4'hF;
    if (state_d == PULSE) pulse_n_d[sel_d] = 1'b0;
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      db_q      <= 1'b1;
      db_cnt_q  <= '0;
      state_q   <= IDLE;
      sel_q     <= SEL_STOP;
      cnt_q     <= '0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      pulse_n_q <= 4'hF;
    end else begin
      db_q      <= db_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ack_err_q <= ack_err_d;
      busy_q    <= (state_d != IDLE);
      pulse_n_q <= pulse_n_d;
    end
  end

  assign STOP_n     = pulse_n_q[SEL_STOP];
  assign CONTINUE_n = pulse_n_q[SEL_CONT];
  assign SWMCL_n    = pulse_n_q[SEL_SWMCL];
  assign LOAD_n     = pulse_n_q[SEL_LOAD];
  assign busy       = busy_q;
  assign ack_err    = ack_err_q;
  assign state      = state_q;

endmodule
